// File: rtl/serial_add16_ctrl.sv
// 16-bit add/subtract done as four registered 4-bit nibble steps, LS nibble first.
// Result appears 4 edges after accept; it is held in DONE until out_ready, and no new operands are taken meanwhile.
module serial_add16_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic        cin,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        cout,
  output logic        ovf,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t      state;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic        carry_q;
  logic [1:0]  idx_q;

  logic [3:0]  a_nib;
  logic [3:0]  b_nib;
  logic [4:0]  nib_sum;
  logic [3:0]  low3_sum;

  always_comb begin
    a_nib    = a_q[{idx_q, 2'b00} +: 4];
    b_nib    = b_q[{idx_q, 2'b00} +: 4];
    nib_sum  = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
    // Bit 3 of the low-3-bit sum is the carry into the nibble's top bit (bit 15 on the last step).
    low3_sum = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, carry_q};
  end

  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      idx_q     <= 2'd0;
      result    <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= op_a;
            b_q     <= sub ? ~op_b : op_b;
            carry_q <= sub ? 1'b1 : cin;
            idx_q   <= 2'd0;
            state   <= ADD;
          end
        end
        ADD: begin
          result[{idx_q, 2'b00} +: 4] <= nib_sum[3:0];
          carry_q <= nib_sum[4];
          idx_q   <= idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            cout      <= nib_sum[4];
            ovf       <= low3_sum[3] ^ nib_sum[4];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_add16_ctrl.md
SERIAL_ADD16_CTRL -- requirements
Module: serial_add16_ctrl

Interface
REQ-001 The block SHALL have these ports:
  clk        in   1   rising-edge clock
  rst        in   1   asynchronous reset, active-high
  in_valid   in   1   operand request valid
  in_ready   out  1   block can accept an operand request
  op_a       in   16  operand A
  op_b       in   16  operand B
  cin        in   1   carry-in (add mode only)
  sub        in   1   0 = A+B+cin, 1 = A-B
  out_valid  out  1   result valid
  out_ready  in   1   consumer accepts result
  result     out  16  sum/difference
  cout       out  1   carry out of bit 15 (sub: 1 = no borrow)
  ovf        out  1   two's-complement overflow
  busy       out  1   state is not IDLE
REQ-002 One clock; reset is asynchronous and active-high.

Function
REQ-003 The block SHALL perform a 16-bit add as four sequential 4-bit nibble additions, least significant nibble first, with the carry registered between nibbles.
REQ-004 The block SHALL have states IDLE, ADD and DONE.
REQ-005 in_ready SHALL be 1 only in IDLE with rst low.
REQ-006 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1, and SHALL latch op_a and op_b, set the nibble index to 0, and go to ADD.
REQ-007 The latched carry SHALL be cin when sub=0, and 1 when sub=1; the latched B SHALL be op_b when sub=0, and ~op_b when sub=1.
REQ-008 In ADD, each edge SHALL:
  - write nibble k as the 4-bit sum of A[4k+3:4k], B[4k+3:4k] and the carry register;
  - update the carry register with that nibble's carry-out;
  - increment k.
REQ-009 On the edge that writes nibble 3, the block SHALL:
  - set cout to the final carry;
  - set ovf = (carry into bit 15) XOR (carry out of bit 15);
  - go to DONE with out_valid=1.
REQ-010 Latency SHALL be exactly 4 clock edges from the accept edge to out_valid=1.
REQ-011 In DONE, result, cout and ovf SHALL hold stable until an edge with out_ready=1, which SHALL return the block to IDLE with out_valid=0.
REQ-012 in_valid in ADD or DONE SHALL be ignored; no operand SHALL be lost or overwritten mid-operation.
REQ-013 Operands SHALL not be accepted in the same cycle a result is released; the minimum spacing between accepts SHALL be 6 cycles.
REQ-014 busy SHALL equal (state != IDLE).
REQ-015 result, cout and ovf SHALL be defined only while out_valid=1; the bench SHALL not check them otherwise.

Reset
REQ-016 When rst is asserted, the block SHALL immediately, without waiting for clk:
  - go to IDLE;
  - clear out_valid, busy, result, cout, ovf, the carry register and the nibble index.
REQ-017 in_ready SHALL be 0 while rst=1 and 1 on the first cycle after release.
REQ-018 Reset during ADD or DONE SHALL abort the operation; no out_valid SHALL follow for it.

Verification
REQ-019 Add: a=0x1234, b=0x4321, cin=0, sub=0 -> out_valid 4 edges after accept; result=0x5555, cout=0, ovf=0.
REQ-020 Full ripple: a=0xFFFF, b=0x0001, cin=0 -> result=0x0000, cout=1, ovf=0.
REQ-021 Signed overflow: a=0x7FFF, b=0x0001, cin=0 -> result=0x8000, cout=0, ovf=1.
REQ-022 Subtract with cin=1 applied: a=0x0005, b=0x0007, sub=1 -> result=0xFFFE, cout=0, ovf=0 (cin ignored).
REQ-023 Backpressure: out_ready=0 for 3 cycles after out_valid, with in_valid=1 and a new operand pair applied throughout -> result stable, in_ready=0, the new pair not accepted. Then out_ready=1 -> IDLE; the pair is accepted on the next edge and produces a correct result.
REQ-024 Reset mid-operation: assert rst after nibble 1 is written -> busy=0 and out_valid=0 immediately; in_ready=1 after release. A following add, 0x0F0F + 0x00F1 with cin=0 -> result=0x1000, cout=0, ovf=0.
